// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-port memory responder.
package mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 10;

    // Issue order: lower index goes first.
    localparam logic [2:0] P_RD1 = 3'd0;
    localparam logic [2:0] P_RD2 = 3'd1;
    localparam logic [2:0] P_RD3 = 3'd2;
    localparam logic [2:0] P_RD4 = 3'd3;
    localparam logic [2:0] P_WR  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [2:0] first_req(input logic [4:0] m);
        logic [2:0] idx;
        idx = P_RD1;
        for (int i = 4; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_sp_ram.sv
module mem_sp_ram #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Serialises up to four reads and one write per transaction onto a single-port RAM,
// stalling the requester until every requested read result is registered.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_write,
    input  logic [ADDR_W-1:0] m_inaddr,
    input  logic [DATA_W-1:0] m_indata,
    input  logic              m_read1,
    input  logic              m_read2,
    input  logic              m_read3,
    input  logic              m_read4,
    input  logic [ADDR_W-1:0] m_outaddr1,
    input  logic [ADDR_W-1:0] m_outaddr2,
    input  logic [ADDR_W-1:0] m_outaddr3,
    input  logic [ADDR_W-1:0] m_outaddr4,
    output logic [DATA_W-1:0] m_outdata1,
    output logic [DATA_W-1:0] m_outdata2,
    output logic [DATA_W-1:0] m_outdata3,
    output logic [DATA_W-1:0] m_outdata4,
    output logic              stall
);

    state_e                 state_q, state_d;
    logic [4:0]             pend_q, pend_d;
    logic [3:0][ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [DATA_W-1:0]      wr_data_q;
    logic                   rd_vld_q;
    logic [1:0]             rd_port_q;
    logic [3:0][DATA_W-1:0] dout_q;

    logic [4:0]        req_vec;
    logic [2:0]        sel;
    logic              ram_we, rd_issue, stall_c;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign req_vec = {m_write, m_read4, m_read3, m_read2, m_read1};

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        sel      = first_req(pend_q);
        ram_we   = 1'b0;
        ram_addr = wr_addr_q;
        rd_issue = 1'b0;
        stall_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req_vec) begin
                    stall_c = 1'b1;
                    pend_d  = req_vec;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall_c = 1'b1;
                pend_d  = pend_q & ~(5'b00001 << sel);
                if (sel == P_WR) begin
                    ram_we = 1'b1;
                end else begin
                    ram_addr = rd_addr_q[sel[1:0]];
                    rd_issue = 1'b1;
                end
                if (pend_d == 5'b0) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                stall_c = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall is forced low while reset is held, even if requests are present.
    assign stall = stall_c & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_port_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            rd_vld_q  <= rd_issue;
            rd_port_q <= sel[1:0];
            if (rd_vld_q) dout_q[rd_port_q] <= ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (state_q == S_IDLE && (|req_vec)) begin
            rd_addr_q <= {m_outaddr4, m_outaddr3, m_outaddr2, m_outaddr1};
            wr_addr_q <= m_inaddr;
            wr_data_q <= m_indata;
        end
    end

    mem_sp_ram #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wr_data_q),
        .rdata(ram_rdata)
    );

    assign m_outdata1 = dout_q[0];
    assign m_outdata2 = dout_q[1];
    assign m_outdata3 = dout_q[2];
    assign m_outdata4 = dout_q[3];

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a transaction-level memory model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_write = 1'b0;
    logic [13:0] m_inaddr = '0;
    logic [9:0]  m_indata = '0;
    logic        m_read1 = 1'b0, m_read2 = 1'b0, m_read3 = 1'b0, m_read4 = 1'b0;
    logic [13:0] m_outaddr1 = '0, m_outaddr2 = '0, m_outaddr3 = '0, m_outaddr4 = '0;
    logic [9:0]  m_outdata1, m_outdata2, m_outdata3, m_outdata4;
    logic        stall;

    int total = 0;
    int bad   = 0;

    logic [9:0]  mdl_mem [int];
    logic [9:0]  exp_out [4];
    logic [13:0] pool [16];

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .rst(rst),
        .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
        .m_read1(m_read1), .m_read2(m_read2), .m_read3(m_read3), .m_read4(m_read4),
        .m_outaddr1(m_outaddr1), .m_outaddr2(m_outaddr2),
        .m_outaddr3(m_outaddr3), .m_outaddr4(m_outaddr4),
        .m_outdata1(m_outdata1), .m_outdata2(m_outdata2),
        .m_outdata3(m_outdata3), .m_outdata4(m_outdata4),
        .stall(stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [9:0] dout(input int i);
        case (i)
            0: return m_outdata1;
            1: return m_outdata2;
            2: return m_outdata3;
            default: return m_outdata4;
        endcase
    endfunction

    task automatic chk_outs(input string nm);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_out%0d", nm, i + 1), 32'(dout(i)), 32'(exp_out[i]));
    endtask

    task automatic set_req(input logic [4:0] r, input logic [3:0][13:0] a,
                           input logic [13:0] wa, input logic [9:0] wd);
        {m_write, m_read4, m_read3, m_read2, m_read1} = r;
        m_outaddr1 = r[0] ? a[0] : 'x;
        m_outaddr2 = r[1] ? a[1] : 'x;
        m_outaddr3 = r[2] ? a[2] : 'x;
        m_outaddr4 = r[3] ? a[3] : 'x;
        m_inaddr   = wa;
        m_indata   = wd;
    endtask

    task automatic zero_req();
        {m_write, m_read4, m_read3, m_read2, m_read1} = '0;
        m_inaddr = '0; m_indata = '0;
        m_outaddr1 = '0; m_outaddr2 = '0; m_outaddr3 = '0; m_outaddr4 = '0;
    endtask

    task automatic scramble();
        {m_write, m_read4, m_read3, m_read2, m_read1} = 5'($urandom);
        m_inaddr = 14'($urandom); m_indata = 10'($urandom);
        m_outaddr1 = 14'($urandom); m_outaddr2 = 14'($urandom);
        m_outaddr3 = 14'($urandom); m_outaddr4 = 14'($urandom);
    endtask

    // Model: reads see memory before this transaction's write; stall high n+2 cycles then one low.
    task automatic run_txn(input logic [4:0] r, input logic [3:0][13:0] a,
                           input logic [13:0] wa, input logic [9:0] wd);
        int n;
        n = $countones(r);
        @(negedge clk);
        set_req(r, a, wa, wd);
        #1;
        if (n == 0) begin
            chk("stall_idle_empty", 32'(stall), 32'd0);
            chk_outs("idle");
            zero_req();
            return;
        end
        chk("stall_latch", 32'(stall), 32'd1);
        for (int i = 0; i < 4; i++) if (r[i]) exp_out[i] = mdl_mem[int'(a[i])];
        if (r[4]) mdl_mem[int'(wa)] = wd;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            scramble();
            #1;
            chk($sformatf("stall_busy_c%0d", c), 32'(stall), 32'd1);
        end
        @(negedge clk);
        scramble();
        #1;
        chk("stall_done", 32'(stall), 32'd0);
        chk_outs("done");
        zero_req();
    endtask

    task automatic wr(input logic [13:0] wa, input logic [9:0] wd);
        run_txn(5'b10000, '0, wa, wd);
    endtask

    initial begin
        logic [3:0][13:0] a;
        for (int i = 0; i < 4; i++) exp_out[i] = '0;
        pool[0] = 14'h2000; pool[1] = 14'h2001; pool[2] = 14'h2002; pool[3] = 14'h0010;
        pool[4] = 14'h0020; pool[5] = 14'h3FFF; pool[6] = 14'h0000;
        for (int i = 7; i < 16; i++) pool[i] = 14'(14'h0400 + i * 14'h0111);

        // Reset state
        repeat (3) @(negedge clk);
        m_read1 = 1'b1; m_write = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk_outs("rst");
        zero_req();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("idle_stall", 32'(stall), 32'd0);
        end

        // Preload through write-only transactions
        wr(14'h2000, 10'h0AA); wr(14'h2001, 10'h155); wr(14'h2002, 10'h3FF);
        wr(14'h0010, 10'h000); wr(14'h0020, 10'h0C3);
        wr(14'h3FFF, 10'h201); wr(14'h0000, 10'h102);
        for (int i = 7; i < 16; i++) wr(pool[i], 10'($urandom));

        // Three reads of the preloaded block
        a = '0; a[0] = 14'h2000; a[1] = 14'h2001; a[2] = 14'h2002;
        run_txn(5'b00111, a, '0, '0);
        chk("lit_rd1", 32'(m_outdata1), 32'h0AA);
        chk("lit_rd2", 32'(m_outdata2), 32'h155);
        chk("lit_rd3", 32'(m_outdata3), 32'h3FF);
        chk("lit_rd4_hold", 32'(m_outdata4), 32'h000);

        // Read and write the same address: read sees old value
        a = '0; a[3] = 14'h0010;
        run_txn(5'b11000, a, 14'h0010, 10'h123);
        chk("lit_rw_old", 32'(m_outdata4), 32'h000);
        a = '0; a[0] = 14'h0010;
        run_txn(5'b00001, a, '0, '0);
        chk("lit_rw_new", 32'(m_outdata1), 32'h123);

        // Address extremes
        a = '0; a[0] = 14'h3FFF; a[1] = 14'h0000;
        run_txn(5'b00011, a, '0, '0);
        chk("lit_top", 32'(m_outdata1), 32'h201);
        chk("lit_bot", 32'(m_outdata2), 32'h102);

        // Reset in the second ISSUE cycle of a full transaction
        a[0] = 14'h2000; a[1] = 14'h2001; a[2] = 14'h2002; a[3] = 14'h3FFF;
        @(negedge clk);
        set_req(5'b11111, a, 14'h0020, 10'h3AB);
        #1; chk("abort_latch", 32'(stall), 32'd1);
        @(negedge clk); #1; chk("abort_issue1", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) exp_out[i] = '0;
        chk("abort_stall", 32'(stall), 32'd0);
        chk_outs("abort");
        zero_req();
        @(negedge clk);
        rst = 1'b1;
        a = '0; a[0] = 14'h0020;
        run_txn(5'b00001, a, '0, '0);
        chk("lit_abort_old", 32'(m_outdata1), 32'h0C3);

        // Random back-to-back transactions
        for (int t = 0; t < 60; t++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 31));
            for (int i = 0; i < 4; i++) a[i] = pool[$urandom_range(0, 15)];
            run_txn(r, a, pool[$urandom_range(0, 15)], 10'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

endmodule
